reg_writeback_unit: RTL and testbench

- Writer-side companion to the 32x32 register file.
- Accepts completed results from the ALU and the load/memory unit and queues them in an in-order FIFO.
- Drains the FIFO at one write per cycle onto the register file write port (write enable, address, data, instruction-valid).
- Exposes a pending-write scoreboard so decode can stall on source registers whose writes are still in flight.

---
 rtl/reg_writeback_unit.sv | 177 +++++++++++++++++
 tb/tb_reg_writeback_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: in-order result queue feeding the register file write port.
// Optional macro WB_FORWARD_EN adds youngest-pending-value forwarding per source.
module reg_writeback_unit #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ALU_VALID,
   input  logic [4:0]        ALU_RD,
   input  logic [DATA_W-1:0] ALU_DATA,
   output logic              ALU_READY,
   input  logic              MEM_VALID,
   input  logic [4:0]        MEM_RD,
   input  logic [DATA_W-1:0] MEM_DATA,
   output logic              MEM_READY,
   output logic              WB_WRITE,
   output logic [4:0]        WB_ADDR,
   output logic [DATA_W-1:0] WB_DATA,
   output logic              WB_HIT,
   input  logic [4:0]        RS1_ADDR,
   input  logic [4:0]        RS2_ADDR,
   output logic              RS1_BUSY,
   output logic              RS2_BUSY
`ifdef WB_FORWARD_EN
   ,
   output logic              RS1_FWD_VALID,
   output logic [DATA_W-1:0] RS1_FWD_DATA,
   output logic              RS2_FWD_VALID,
   output logic [DATA_W-1:0] RS2_FWD_DATA
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [4:0]        rd_q   [DEPTH];
   logic [4:0]        rd_d   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic              wb_write_q, wb_write_d;
   logic [4:0]        wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic [DEPTH-1:0]  valid;
   logic              mem_acc;
   logic              alu_acc;
   logic              mem_st;
   logic              alu_st;
   logic              deq;
   logic [PW-1:0]     alu_idx;

   // Pending check: queued entry or the write currently on the port.
   function automatic logic pend(input logic [4:0] a);
      logic hit;
      hit = wb_write_q && (wb_addr_q == a);
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (rd_q[i] == a)) begin
            hit = 1'b1;
         end
      end
      return (a != 5'd0) && hit;
   endfunction

`ifdef WB_FORWARD_EN
   // Youngest value: walk oldest to youngest so the last match wins.
   function automatic logic [DATA_W-1:0] fwd(input logic [4:0] a);
      logic [DATA_W-1:0] v;
      logic [PW-1:0]     idx;
      v = wb_data_q;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rptr_q + PW'(k);
         if (({1'b0, PW'(k)} < count_q) && (rd_q[idx] == a)) begin
            v = data_q[idx];
         end
      end
      return v;
   endfunction
`endif

   // Ready from current occupancy; the load path claims a slot first.
   always_comb begin
      MEM_READY = (count_q != FULL);
      mem_acc   = MEM_VALID & MEM_READY;
      ALU_READY = (({1'b0, count_q} + {{CW{1'b0}}, mem_acc})
                  < {1'b0, FULL});
   end

   // Slot occupancy relative to the read pointer.
   always_comb begin
      valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = ({1'b0, PW'(i) - rptr_q} < count_q);
      end
   end

   // Enqueue (load before ALU, x0 dropped) and pop of the head.
   always_comb begin
      rd_d    = rd_q;
      data_d  = data_q;
      alu_acc = ALU_VALID & ALU_READY;
      mem_st  = mem_acc & (MEM_RD != 5'd0);
      alu_st  = alu_acc & (ALU_RD != 5'd0);
      deq     = (count_q != '0);
      alu_idx = wptr_q + PW'(mem_st);
      if (mem_st) begin
         rd_d[wptr_q]   = MEM_RD;
         data_d[wptr_q] = MEM_DATA;
      end
      if (alu_st) begin
         rd_d[alu_idx]   = ALU_RD;
         data_d[alu_idx] = ALU_DATA;
      end
      wptr_d  = wptr_q + PW'(mem_st) + PW'(alu_st);
      rptr_d  = rptr_q + PW'(deq);
      count_d = count_q + CW'(mem_st) + CW'(alu_st) - CW'(deq);
      wb_write_d = deq;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      if (deq) begin
         wb_addr_d = rd_q[rptr_q];
         wb_data_d = data_q[rptr_q];
      end
   end

   // Control state and write-port registers; reset discards everything.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         wb_write_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         wb_write_q <= wb_write_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
      end
   end

   // Entry storage; contents are qualified by occupancy, so no reset.
   always_ff @(posedge CLK) begin
      rd_q   <= rd_d;
      data_q <= data_d;
   end

   // Write port and scoreboard outputs.
   always_comb begin
      WB_WRITE = wb_write_q;
      WB_HIT   = wb_write_q;
      WB_ADDR  = wb_addr_q;
      WB_DATA  = wb_data_q;
      RS1_BUSY = pend(RS1_ADDR);
      RS2_BUSY = pend(RS2_ADDR);
   end

`ifdef WB_FORWARD_EN
   // Forwarded values accompany the busy indication.
   always_comb begin
      RS1_FWD_VALID = pend(RS1_ADDR);
      RS2_FWD_VALID = pend(RS2_ADDR);
      RS1_FWD_DATA  = fwd(RS1_ADDR);
      RS2_FWD_DATA  = fwd(RS2_ADDR);
   end
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: scoreboard bench for reg_writeback_unit.
// DEPTH=2 so the full-queue back-pressure case is reachable.
module tb_reg_writeback_unit;

   localparam int DEPTH = 2;
   localparam int DW    = 32;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          ALU_VALID;
   logic [4:0]    ALU_RD;
   logic [DW-1:0] ALU_DATA;
   logic          ALU_READY;
   logic          MEM_VALID;
   logic [4:0]    MEM_RD;
   logic [DW-1:0] MEM_DATA;
   logic          MEM_READY;
   logic          WB_WRITE;
   logic [4:0]    WB_ADDR;
   logic [DW-1:0] WB_DATA;
   logic          WB_HIT;
   logic [4:0]    RS1_ADDR;
   logic [4:0]    RS2_ADDR;
   logic          RS1_BUSY;
   logic          RS2_BUSY;
`ifdef WB_FORWARD_EN
   logic          RS1_FWD_VALID;
   logic [DW-1:0] RS1_FWD_DATA;
   logic          RS2_FWD_VALID;
   logic [DW-1:0] RS2_FWD_DATA;
`endif

   reg_writeback_unit #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .ALU_VALID (ALU_VALID),
      .ALU_RD    (ALU_RD),
      .ALU_DATA  (ALU_DATA),
      .ALU_READY (ALU_READY),
      .MEM_VALID (MEM_VALID),
      .MEM_RD    (MEM_RD),
      .MEM_DATA  (MEM_DATA),
      .MEM_READY (MEM_READY),
      .WB_WRITE  (WB_WRITE),
      .WB_ADDR   (WB_ADDR),
      .WB_DATA   (WB_DATA),
      .WB_HIT    (WB_HIT),
      .RS1_ADDR  (RS1_ADDR),
      .RS2_ADDR  (RS2_ADDR),
      .RS1_BUSY  (RS1_BUSY),
      .RS2_BUSY  (RS2_BUSY)
`ifdef WB_FORWARD_EN
      ,
      .RS1_FWD_VALID (RS1_FWD_VALID),
      .RS1_FWD_DATA  (RS1_FWD_DATA),
      .RS2_FWD_VALID (RS2_FWD_VALID),
      .RS2_FWD_DATA  (RS2_FWD_DATA)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [4:0]    rd;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          sb[$];
   int            checks = 0;
   int            errors = 0;
   logic          wb_w;
   logic [4:0]    wb_a;
   logic [DW-1:0] wb_d;
   bit            acc_mem;
   bit            acc_alu;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic bit m_busy(input logic [4:0] a);
      bit h;
      h = wb_w && (wb_a == a);
      foreach (sb[i]) if (sb[i].rd == a) h = 1'b1;
      return (a != 5'd0) && h;
   endfunction

`ifdef WB_FORWARD_EN
   function automatic logic [DW-1:0] m_fwd(input logic [4:0] a);
      logic [DW-1:0] v;
      v = wb_d;
      foreach (sb[i]) if (sb[i].rd == a) v = sb[i].d;
      return v;
   endfunction
`endif

   task automatic tick();
      bit   er_m;
      bit   er_a;
      bit   ew;
      ent_t e;
      #1;
      er_m    = (sb.size() < DEPTH);
      acc_mem = MEM_VALID && er_m;
      er_a    = ((sb.size() + (acc_mem ? 1 : 0)) < DEPTH);
      acc_alu = ALU_VALID && er_a;
      chk("mem_ready", 64'(MEM_READY), 64'(er_m));
      chk("alu_ready", 64'(ALU_READY), 64'(er_a));
      ew = (sb.size() > 0);
      if (RESET) begin
         sb.delete();
         ew = 1'b0;
      end else begin
         if (acc_mem && MEM_RD != 5'd0) begin
            e.rd = MEM_RD;
            e.d  = MEM_DATA;
            sb.push_back(e);
         end
         if (acc_alu && ALU_RD != 5'd0) begin
            e.rd = ALU_RD;
            e.d  = ALU_DATA;
            sb.push_back(e);
         end
      end
      @(posedge CLK);
      @(negedge CLK);
      chk("wb_write", 64'(WB_WRITE), 64'(ew));
      chk("wb_hit", 64'(WB_HIT), 64'(ew));
      if (ew) begin
         e    = sb.pop_front();
         wb_a = e.rd;
         wb_d = e.d;
      end
      if (RESET) begin
         wb_a = '0;
         wb_d = '0;
      end
      wb_w = ew;
      chk("wb_addr", 64'(WB_ADDR), 64'(wb_a));
      chk("wb_data", 64'(WB_DATA), 64'(wb_d));
      chk("rs1_busy", 64'(RS1_BUSY), 64'(m_busy(RS1_ADDR)));
      chk("rs2_busy", 64'(RS2_BUSY), 64'(m_busy(RS2_ADDR)));
`ifdef WB_FORWARD_EN
      chk("rs1_fwd_v", 64'(RS1_FWD_VALID), 64'(m_busy(RS1_ADDR)));
      chk("rs2_fwd_v", 64'(RS2_FWD_VALID), 64'(m_busy(RS2_ADDR)));
      if (m_busy(RS1_ADDR))
         chk("rs1_fwd_d", 64'(RS1_FWD_DATA), 64'(m_fwd(RS1_ADDR)));
      if (m_busy(RS2_ADDR))
         chk("rs2_fwd_d", 64'(RS2_FWD_DATA), 64'(m_fwd(RS2_ADDR)));
`endif
   endtask

   task automatic idle(input int n);
      MEM_VALID = 1'b0;
      ALU_VALID = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int na;
      int nm;
      RESET     = 1'b1;
      ALU_VALID = 1'b0;
      ALU_RD    = '0;
      ALU_DATA  = '0;
      MEM_VALID = 1'b0;
      MEM_RD    = '0;
      MEM_DATA  = '0;
      RS1_ADDR  = '0;
      RS2_ADDR  = '0;
      wb_w      = 1'b0;
      wb_a      = '0;
      wb_d      = '0;
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_write", 64'(WB_WRITE), 64'd0);
      chk("rst_hit", 64'(WB_HIT), 64'd0);
      chk("rst_addr", 64'(WB_ADDR), 64'd0);
      chk("rst_data", 64'(WB_DATA), 64'd0);
      RESET    = 1'b0;
      RS1_ADDR = 5'd5;
      idle(1);

      // single ALU result to r5
      ALU_VALID = 1'b1;
      ALU_RD    = 5'd5;
      ALU_DATA  = 32'h0000_002A;
      tick();
      idle(3);

      // load and ALU together, load first
      RS1_ADDR  = 5'd3;
      RS2_ADDR  = 5'd4;
      MEM_VALID = 1'b1;
      MEM_RD    = 5'd3;
      MEM_DATA  = 32'h11;
      ALU_VALID = 1'b1;
      ALU_RD    = 5'd4;
      ALU_DATA  = 32'h22;
      tick();
      idle(3);

      // ALU held valid with 8 distinct destinations
      na = 0;
      ALU_VALID = 1'b1;
      for (int c = 0; c < 40 && na < 8; c++) begin
         ALU_RD   = 5'(na + 10);
         ALU_DATA = 32'h100 + 32'(na);
         RS1_ADDR = 5'(na + 10);
         tick();
         if (acc_alu) na++;
      end
      ALU_VALID = 1'b0;
      chk("hold_done", 64'(na), 64'd8);
      idle(3);

      // both sources held: fills the queue and exercises back-pressure
      na = 0;
      nm = 0;
      for (int c = 0; c < 40 && (na < 4 || nm < 4); c++) begin
         MEM_VALID = (nm < 4);
         MEM_RD    = 5'(nm + 20);
         MEM_DATA  = 32'hA00 + 32'(nm);
         ALU_VALID = (na < 4);
         ALU_RD    = 5'(na + 24);
         ALU_DATA  = 32'hB00 + 32'(na);
         RS1_ADDR  = 5'(nm + 20);
         RS2_ADDR  = 5'(na + 24);
         tick();
         if (acc_mem) nm++;
         if (acc_alu) na++;
      end
      chk("full_done", 64'(na + nm), 64'd8);
      idle(3);

      // x0 results are accepted and dropped
      RS1_ADDR  = 5'd0;
      RS2_ADDR  = 5'd6;
      ALU_VALID = 1'b1;
      ALU_RD    = 5'd0;
      ALU_DATA  = 32'hFFFF_FFFF;
      tick();
      MEM_VALID = 1'b1;
      MEM_RD    = 5'd0;
      MEM_DATA  = 32'hDEAD_BEEF;
      ALU_RD    = 5'd6;
      ALU_DATA  = 32'h66;
      tick();
      idle(3);

      // reset with writes in flight
      RS1_ADDR  = 5'd9;
      RS2_ADDR  = 5'd10;
      MEM_VALID = 1'b1;
      MEM_RD    = 5'd9;
      MEM_DATA  = 32'h99;
      ALU_VALID = 1'b1;
      ALU_RD    = 5'd10;
      ALU_DATA  = 32'h1010;
      tick();
      MEM_VALID = 1'b0;
      ALU_VALID = 1'b0;
      RESET     = 1'b1;
      tick();
      RESET = 1'b0;
      idle(3);

      // two pending writes to r7, youngest is 0x2
      RS1_ADDR  = 5'd7;
      RS2_ADDR  = 5'd7;
      MEM_VALID = 1'b1;
      MEM_RD    = 5'd7;
      MEM_DATA  = 32'h1;
      ALU_VALID = 1'b1;
      ALU_RD    = 5'd7;
      ALU_DATA  = 32'h2;
      tick();
      idle(4);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
